// File: rtl/button_irq_ctrl.sv
// button_irq_ctrl: Avalon-MM push-button controller.
// Each button is synchronised with two flops, debounced by a per-bit hold
// counter, and its qualified edges are latched into a sticky edge register.
// A maskable, registered level interrupt is raised from the edge register.
// Optional feature macro: BUTTON_IRQ_CTRL_EVENT_CNT_EN adds a 16-bit
// saturating qualified-edge counter at word address 4.
module button_irq_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic [15:0]      count_view;

    logic wr_mask;
    logic wr_edge;

    // Upper write-data bits are simply not stored anywhere.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_mask = write && (address == 3'd2);
    assign wr_edge = write && (address == 3'd3);

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE_VEC;
            sync2_q <= IDLE_VEC;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a bit flips only after the synchronised level has
    // disagreed with the accepted level for DEBOUNCE_CYCLES straight cycles.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CW-1:0] cnt_q;
            logic          differ;
            logic          expire;

            assign differ   = sync2_q[gi] != stable_q[gi];
            assign expire   = differ && (cnt_q == CNT_LAST);
            assign flip[gi] = expire;

            // Hold counter: cleared on agreement or on acceptance.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (!differ || expire) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    endgenerate

    assign stable_d = stable_q ^ flip;

    // Edge qualification from the previous and current debounced levels.
    generate
        if (EDGE_TYPE == 0) begin : g_fall
            assign edge_pulse = stable_dly_q & ~stable_q;
        end else if (EDGE_TYPE == 1) begin : g_rise
            assign edge_pulse = ~stable_dly_q & stable_q;
        end else begin : g_both
            assign edge_pulse = stable_dly_q ^ stable_q;
        end
    endgenerate

    // Sticky edges: write-1-to-clear, a new edge in the same cycle wins.
    always_comb begin
        edge_d = edge_q;
        if (wr_edge) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | edge_pulse;
    end

    // Mask register write.
    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = writedata[WIDTH-1:0];
        end
    end

    // Interrupt from the registered edge and mask state only.
    assign irq_d = |(edge_q & mask_q);

`ifdef BUTTON_IRQ_CTRL_EVENT_CNT_EN
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [16:0] count_sum;
    logic [5:0]  edge_pop;
    logic        wr_count;

    assign wr_count = write && (address == 3'd4);

    // Saturating event count; a clear in the same cycle keeps this cycle's edges.
    always_comb begin
        edge_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_pop = edge_pop + 6'(edge_pulse[i]);
        end
        count_sum = (wr_count ? 17'd0 : {1'b0, count_q}) + 17'(edge_pop);
        count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Event counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_view = count_q;
`else
    assign count_view = 16'h0000;
`endif

    // Read mux sampled only on a read strobe; uses pre-write register values.
    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            readdata_d = '0;
            case (address)
                3'd0:    readdata_d[WIDTH-1:0] = stable_q;
                3'd1:    readdata_d[WIDTH-1:0] = sync2_q;
                3'd2:    readdata_d[WIDTH-1:0] = mask_q;
                3'd3:    readdata_d[WIDTH-1:0] = edge_q;
                3'd4:    readdata_d[15:0]      = count_view;
                default: readdata_d            = '0;
            endcase
        end
    end

    // Debounced state, edge/mask registers, read data and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q     <= IDLE_VEC;
            stable_dly_q <= IDLE_VEC;
            edge_q       <= '0;
            mask_q       <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edge_q       <= edge_d;
            mask_q       <= mask_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
